hash_dispatch_scheduler: RTL
============================

# hash_dispatch_scheduler

Controller that shares a bank of `micro_ucr_hash` engines across a nonce search. It dispatches sequential nonces to whichever engine is free and checks each returned hash against the target. It stops on the first hit, then drains in-flight engines before reporting. It replaces the fixed two-engine lock-step sequencing in the mining top level with an N-engine, free-running scheduler.

## Interface
Parameters:
- `N_ENG`, default 2: number of hash engines driven (1..8).

Ports:
- `clk` — input, 1 bit. Single clock; all logic on the rising edge.
- `reset` — input, 1 bit. Synchronous, active-high. Shared with the engines.
- `start` — input, 1 bit. Begin search; sampled only in IDLE.
- `target` — input, 8 bits. Difficulty threshold; latched at start.
- `block` — input, 96 bits. Block payload; latched at start.
- `nonce_base` — input, 32 bits. First nonce to try; latched at start.
- `terminado` — output, 1 bit. One-cycle pulse when search ends (hit or exhausted).
- `found` — output, 1 bit. 1 = hit found; valid from the `terminado` pulse until the next accepted start.
- `nonce` — output, 32 bits. Winning nonce, byte-reversed: {n[7:0], n[15:8], n[23:16], n[31:24]}.
- `busy` — output, 1 bit. High in any state other than IDLE.
- `hash_count` — output, 32 bits. Number of engine results accepted since start; saturates at 0xFFFFFFFF.
- `eng_init` — output, N_ENG bits. Per-engine one-cycle `hash_init` pulse.
- `eng_valid` — output, 1 bit. Tied high whenever `busy`.
- `eng_block` — output, 128·N_ENG bits. Per-engine input {nonce, block}; slice i is bits [128i+127:128i].
- `eng_hash` — input, 24·N_ENG bits. Per-engine hash result.
- `eng_ready` — input, N_ENG bits. Per-engine `hash_ready`. Result valid in the cycle this is high.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - On `start`=1: latch target/block/nonce_base; set next_nonce←nonce_base, inflight←0, exhausted←0, hash_count←0, found←0; go to RUN.
  - `start` is ignored in all other states.
- **RUN, dispatch**
  - Each cycle, pick the lowest-index engine i with inflight[i]=0.
  - If such an engine exists and exhausted=0, at the edge:
    - set eng_init[i]←1 (all other bits 0);
    - eng_block slice i←{next_nonce, block};
    - slot_nonce[i]←next_nonce; inflight[i]←1;
    - next_nonce←next_nonce+1 (32-bit wrap).
  - At most one dispatch per cycle.
  - Dispatching nonce 0xFFFFFFFF sets exhausted←1.
- **RUN, collect**
  - `eng_ready[i]` is accepted only when inflight[i]=1; otherwise it is ignored and does not count.
  - Accepted ready: inflight[i]←0 at the edge; hash_count+1 per accepted engine that cycle (multiple accepts add their count).
  - An engine freed at edge k is first eligible for dispatch in the cycle after edge k.
  - Hit test: hash[23:16] ≤ target AND hash[15:8] ≤ target (unsigned, ≤ inclusive).
  - Several hits in one cycle: the lowest engine index wins.
  - On hit: nonce←byte-reversed slot_nonce[winner], found←1, go to DRAIN. No dispatch occurs on the hit edge.
  - If exhausted=1 and inflight=0 with no hit: go to DRAIN (found=0).
- **DRAIN**
  - No dispatch.
  - Accepted results still clear inflight and still count, but their hits are ignored.
  - When inflight=0, go to DONE.
- **DONE**
  - terminado=1 for this one cycle; next state is IDLE.
  - `found`, `nonce`, and `hash_count` hold until the next accepted start.
- **Reset values:** state IDLE; terminado, found, busy, eng_init, eng_valid = 0; nonce, hash_count, eng_block = 0; inflight, exhausted = 0.
- **Reset mid-operation:** everything returns to reset values at that edge. The engines reset with it, so no stale ready is accepted afterwards.

## Timing
- `start` sampled at edge E0 (IDLE→RUN).
- First dispatch: eng_init[0] high after E1. Engine 1 follows after E2, and so on, one engine per edge.
- `eng_init` is registered: high for exactly one cycle per dispatch. The eng_block slice is stable from that edge until the next dispatch to the same engine.
- Hit visible on eng_ready at cycle c → found/nonce registered at edge c+1.
- With nothing in flight: DRAIN at c+1, DONE at c+2 (terminado high), IDLE at c+3.
- Minimum restart: `start` held high is accepted at the first IDLE edge after DONE.

## Test plan
Benches use a behavioural engine model with fixed latency L (ready pulses L cycles after init); hash is a per-nonce lookup.

1. N_ENG=2, L=4, target=10, base=0, hit only at nonce 5 (hash 0x0A0A00) → found=1, nonce=0x05000000, one terminado pulse. No eng_init after the hit edge; hash_count equals the number of results accepted.
2. Simultaneous ready on engines 0 and 1 (nonces 2 and 3 both hit) → nonce=0x02000000.
3. Compare boundary, target=10: hash 0x0A0A77 → hit; 0x0B0000 → miss; 0x000B00 → miss.
4. Exhaustion: base=0xFFFFFFFE, no hits → nonces FFFFFFFE and FFFFFFFF dispatched, then no further eng_init. terminado pulses with found=0, hash_count=2.
5. Reset asserted mid-RUN with 2 engines in flight → next cycle busy=0, eng_init=0, hash_count=0, found=0. A subsequent start restarts from nonce_base.
6. `start` pulsed during RUN → ignored: nonce sequence unchanged and no re-latch of target. Late engine hit arriving in DRAIN → `nonce` unchanged.

Source files
------------

// File: rtl/hash_dispatch_scheduler.sv
// Shares a bank of N_ENG hash engines across a sequential nonce search: dispatches to the
// lowest free engine, stops on the first hit, drains in-flight engines, then reports.

module hds_lane (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         disp_i,
    input  logic [31:0]  nonce_i,
    input  logic [95:0]  block_i,
    input  logic [7:0]   target_i,
    input  logic         ready_i,
    input  logic [23:0]  hash_i,
    output logic         inflight_o,
    output logic         accept_o,
    output logic         hit_o,
    output logic [31:0]  slot_nonce_o,
    output logic [127:0] eng_block_o
);
    logic         inflight_q, inflight_d;
    logic [31:0]  slot_nonce_q;
    logic [127:0] eng_block_q;

    // A ready from an engine we did not dispatch to is stale and must be dropped.
    assign accept_o     = ready_i & inflight_q;
    assign hit_o        = accept_o & (hash_i[23:16] <= target_i) & (hash_i[15:8] <= target_i);
    assign inflight_o   = inflight_q;
    assign slot_nonce_o = slot_nonce_q;
    assign eng_block_o  = eng_block_q;

    always_comb begin
        inflight_d = inflight_q;
        if (clr_i)         inflight_d = 1'b0;
        else if (disp_i)   inflight_d = 1'b1;
        else if (accept_o) inflight_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q   <= 1'b0;
            slot_nonce_q <= '0;
            eng_block_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            if (disp_i) begin
                slot_nonce_q <= nonce_i;
                eng_block_q  <= {nonce_i, block_i};
            end
        end
    end
endmodule

module hash_dispatch_scheduler #(
    parameter int N_ENG = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            target,
    input  logic [95:0]           block,
    input  logic [31:0]           nonce_base,
    output logic                  terminado,
    output logic                  found,
    output logic [31:0]           nonce,
    output logic                  busy,
    output logic [31:0]           hash_count,
    output logic [N_ENG-1:0]      eng_init,
    output logic                  eng_valid,
    output logic [128*N_ENG-1:0]  eng_block,
    input  logic [24*N_ENG-1:0]   eng_hash,
    input  logic [N_ENG-1:0]      eng_ready
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              target_q;
    logic [95:0]             block_q;
    logic [31:0]             next_nonce_q;
    logic                    exhausted_q;
    logic [31:0]             hash_count_q, hash_count_d;
    logic                    found_q;
    logic [31:0]             nonce_q;
    logic [N_ENG-1:0]        eng_init_q;

    logic [N_ENG-1:0]        inflight, accept, hit, free_oh, disp_vec;
    logic [N_ENG-1:0][31:0]  slot_nonce;
    logic                    start_acc, free_any, hit_any, hit_run, disp_en;
    logic [31:0]             win_nonce;
    logic [3:0]              acc_cnt;
    logic [32:0]             count_sum;

    for (genvar g = 0; g < N_ENG; g++) begin : g_lane
        hds_lane u_lane (
            .clk          (clk),
            .reset        (reset),
            .clr_i        (start_acc),
            .disp_i       (disp_vec[g]),
            .nonce_i      (next_nonce_q),
            .block_i      (block_q),
            .target_i     (target_q),
            .ready_i      (eng_ready[g]),
            .hash_i       (eng_hash[24*g +: 24]),
            .inflight_o   (inflight[g]),
            .accept_o     (accept[g]),
            .hit_o        (hit[g]),
            .slot_nonce_o (slot_nonce[g]),
            .eng_block_o  (eng_block[128*g +: 128])
        );
    end

    // Scan high-to-low so the lowest index ends up winning both free pick and hit pick.
    always_comb begin
        free_any  = 1'b0;
        free_oh   = '0;
        hit_any   = 1'b0;
        win_nonce = '0;
        acc_cnt   = '0;
        for (int i = N_ENG - 1; i >= 0; i--) begin
            if (!inflight[i]) begin
                free_any   = 1'b1;
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
            if (hit[i]) begin
                hit_any   = 1'b1;
                win_nonce = slot_nonce[i];
            end
            acc_cnt = acc_cnt + 4'(accept[i]);
        end
    end

    always_comb begin
        start_acc    = (state_q == IDLE) && start;
        hit_run      = (state_q == RUN) && hit_any;
        disp_en      = (state_q == RUN) && !hit_any && free_any && !exhausted_q;
        disp_vec     = disp_en ? free_oh : '0;
        count_sum    = {1'b0, hash_count_q} + 33'(acc_cnt);
        hash_count_d = count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (hit_any || (exhausted_q && inflight == '0)) state_d = DRAIN;
            DRAIN:   if (inflight == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        terminado = (state_q == DONE);
        eng_valid = busy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target_q     <= '0;
            block_q      <= '0;
            next_nonce_q <= '0;
            exhausted_q  <= 1'b0;
            hash_count_q <= '0;
            found_q      <= 1'b0;
            nonce_q      <= '0;
            eng_init_q   <= '0;
        end else begin
            eng_init_q <= disp_vec;
            if (start_acc) begin
                target_q     <= target;
                block_q      <= block;
                next_nonce_q <= nonce_base;
                exhausted_q  <= 1'b0;
                hash_count_q <= '0;
                found_q      <= 1'b0;
                nonce_q      <= '0;
            end else begin
                hash_count_q <= hash_count_d;
                if (disp_en) begin
                    next_nonce_q <= next_nonce_q + 32'd1;
                    if (next_nonce_q == 32'hFFFF_FFFF) exhausted_q <= 1'b1;
                end
                if (hit_run) begin
                    found_q <= 1'b1;
                    nonce_q <= {win_nonce[7:0], win_nonce[15:8], win_nonce[23:16], win_nonce[31:24]};
                end
            end
        end
    end

    assign found      = found_q;
    assign nonce      = nonce_q;
    assign hash_count = hash_count_q;
    assign eng_init   = eng_init_q;
endmodule
